grb_frame_counter: RTL and testbench

Parametrised position counter for the GRB LED serial driver. It tracks the current bit within a colour byte, the colour byte within an LED, and the LED within a frame, and also keeps a flat bit total. It sits between the driver state machine, which issues increment and clear strobes, and the shift/encode datapath, which uses the indices to select the outgoing bit. It raises terminal flags and end-of-frame events so the state machine can decide when to emit the latch/reset gap. It supports arbitrary strip lengths, 3- or 4-byte LEDs, and either one-shot or wrapping frames.

---
 rtl/grb_pkg.sv | 35 +++
 rtl/grb_frame_counter_if.sv | 49 ++++
 rtl/grb_mod_counter.sv | 60 ++++++
 rtl/grb_frame_counter.sv | 141 ++++++++++++++
 tb/tb_grb_frame_counter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : grb_pkg
// Purpose : Shared constants and helpers for the GRB LED serial driver.
//           Holds the byte geometry of a colour pixel, the colour byte index
//           values seen on byte_idx, and a constant clog2 used for deriving
//           port widths at elaboration time.
// Revision: 1.0  initial release
// ============================================================================
package grb_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BYTES_GRB     = 3;
    localparam int BYTES_GRBW    = 4;

    // Colour byte order on the wire: G first, then R, B and (GRBW only) W.
    localparam logic [1:0] IDX_G = 2'd0;
    localparam logic [1:0] IDX_R = 2'd1;
    localparam logic [1:0] IDX_B = 2'd2;
    localparam logic [1:0] IDX_W = 2'd3;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << result) < 64'(value)) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage : grb_pkg
`default_nettype wire

// File: rtl/grb_frame_counter_if.sv
`default_nettype none
// ============================================================================
// Module  : grb_frame_counter_if
// Purpose : Strobe/index bundle between the driver state machine (master)
//           and the frame position counter (slave).
// Ports   : clear_i, inc_i       strobes from the state machine
//           bit_idx, byte_idx,   current position within the frame
//           pixel_idx
//           total_count          accepted increments since clear
//           last_bit, last_byte, last_pixel, frame_end  position decodes
//           done, frame_pulse    frame completion status
// Revision: 1.0  initial release
// ============================================================================
interface grb_frame_counter_if #(
    parameter int NUM_LEDS      = 10,
    parameter int BYTES_PER_LED = 3
);
    import grb_pkg::*;

    localparam int PIX_W = (clog2(NUM_LEDS) > 1) ? clog2(NUM_LEDS) : 1;
    localparam int CNT_W = clog2(NUM_LEDS * BYTES_PER_LED * BITS_PER_BYTE + 1);

    logic             clear_i;
    logic             inc_i;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [PIX_W-1:0] pixel_idx;
    logic [CNT_W-1:0] total_count;
    logic             last_bit;
    logic             last_byte;
    logic             last_pixel;
    logic             frame_end;
    logic             done;
    logic             frame_pulse;

    modport master (
        output clear_i, inc_i,
        input  bit_idx, byte_idx, pixel_idx, total_count,
        input  last_bit, last_byte, last_pixel, frame_end, done, frame_pulse
    );

    modport slave (
        input  clear_i, inc_i,
        output bit_idx, byte_idx, pixel_idx, total_count,
        output last_bit, last_byte, last_pixel, frame_end, done, frame_pulse
    );

endinterface : grb_frame_counter_if
`default_nettype wire

// File: rtl/grb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : grb_mod_counter
// Purpose : Modulo-N counter with synchronous clear and terminal decode.
// Ports   : clk, reset   clock, synchronous active-high reset
//           clear_i      return to 0 (wins over inc_i)
//           inc_i        advance by one, wrapping N-1 -> 0
//           value_o      current count, 0..N-1
//           terminal_o   value_o == N-1 (combinational)
// Revision: 1.0  initial release
// ============================================================================
module grb_mod_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clear_i,
    input  wire logic         inc_i,
    output logic [W-1:0]      value_o,
    output logic              terminal_o
);

    generate
        if (N == 1) begin : g_single
            // A single-state counter never moves and is always terminal.
            wire w_unused = &{1'b0, clk, reset, clear_i, inc_i};
            assign value_o    = '0;
            assign terminal_o = 1'b1;
        end else begin : g_multi
            logic [W-1:0] value_q;
            logic [W-1:0] value_d;
            logic         w_term;

            assign w_term = (value_q == W'(N - 1));

            always_comb begin
                value_d = value_q;
                if (clear_i) begin
                    value_d = '0;
                end else if (inc_i) begin
                    value_d = w_term ? '0 : value_q + W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    value_q <= '0;
                end else begin
                    value_q <= value_d;
                end
            end

            assign value_o    = value_q;
            assign terminal_o = w_term;
        end
    endgenerate

endmodule : grb_mod_counter
`default_nettype wire

// File: rtl/grb_frame_counter.sv
`default_nettype none
// ============================================================================
// Module  : grb_frame_counter
// Purpose : Bit / colour-byte / LED position counter for the GRB serial
//           driver, with flat bit total, terminal decodes, end-of-frame
//           pulse and either one-shot (WRAP=0) or wrapping (WRAP=1) frames.
// Ports   : clk, reset   clock, synchronous active-high reset
//           cnt_if       slave side of grb_frame_counter_if (strobes in,
//                        indices / flags out)
// Revision: 1.0  initial release
// ============================================================================
module grb_frame_counter
    import grb_pkg::*;
#(
    parameter int NUM_LEDS      = 10,
    parameter int BYTES_PER_LED = 3,
    parameter int WRAP          = 0
) (
    input wire logic           clk,
    input wire logic           reset,
    grb_frame_counter_if.slave cnt_if
);

    localparam int PIX_W      = (clog2(NUM_LEDS) > 1) ? clog2(NUM_LEDS) : 1;
    localparam int CNT_W      = clog2(NUM_LEDS * BYTES_PER_LED * BITS_PER_BYTE + 1);
    localparam int FRAME_BITS = NUM_LEDS * BYTES_PER_LED * BITS_PER_BYTE;

    generate
        if ((BYTES_PER_LED != BYTES_GRB) && (BYTES_PER_LED != BYTES_GRBW)) begin : g_bad_bytes
            $error("grb_frame_counter: BYTES_PER_LED must be 3 or 4");
        end
        if (NUM_LEDS < 1) begin : g_bad_leds
            $error("grb_frame_counter: NUM_LEDS must be at least 1");
        end
    endgenerate

    logic             w_accept;
    logic             w_bit_inc;
    logic             w_byte_inc;
    logic             w_pix_inc;
    logic [2:0]       w_bit;
    logic [1:0]       w_byte;
    logic [PIX_W-1:0] w_pix;
    logic             w_bit_term;
    logic             w_byte_term;
    logic             w_pix_term;
    logic             w_frame_end;

    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] total_d;
    logic             done_q;
    logic             done_d;
    logic             pulse_q;
    logic             pulse_d;

    assign w_frame_end = w_bit_term & w_byte_term & w_pix_term;

    // Clear takes priority, and a finished one-shot frame ignores increments.
    assign w_accept = cnt_if.inc_i & ~cnt_if.clear_i & ~done_q;

    // In one-shot mode the final increment must leave the indices parked on
    // the last position; in wrap mode the chained counters roll to 0 by
    // themselves.
    assign w_bit_inc  = w_accept & ~(w_frame_end & (WRAP == 0));
    assign w_byte_inc = w_bit_inc & w_bit_term;
    assign w_pix_inc  = w_byte_inc & w_byte_term;

    grb_mod_counter #(.N(BITS_PER_BYTE), .W(3)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_if.clear_i),
        .inc_i      (w_bit_inc),
        .value_o    (w_bit),
        .terminal_o (w_bit_term)
    );

    grb_mod_counter #(.N(BYTES_PER_LED), .W(2)) u_byte_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_if.clear_i),
        .inc_i      (w_byte_inc),
        .value_o    (w_byte),
        .terminal_o (w_byte_term)
    );

    grb_mod_counter #(.N(NUM_LEDS), .W(PIX_W)) u_pix_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_if.clear_i),
        .inc_i      (w_pix_inc),
        .value_o    (w_pix),
        .terminal_o (w_pix_term)
    );

    always_comb begin
        total_d = total_q;
        done_d  = done_q;
        pulse_d = 1'b0;
        if (cnt_if.clear_i) begin
            total_d = '0;
            done_d  = 1'b0;
        end else if (w_accept) begin
            pulse_d = w_frame_end;
            if (w_frame_end) begin
                if (WRAP != 0) begin
                    total_d = '0;
                end else begin
                    total_d = CNT_W'(FRAME_BITS);
                    done_d  = 1'b1;
                end
            end else begin
                total_d = total_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            total_q <= total_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    assign cnt_if.bit_idx     = w_bit;
    assign cnt_if.byte_idx    = w_byte;
    assign cnt_if.pixel_idx   = w_pix;
    assign cnt_if.total_count = total_q;
    assign cnt_if.last_bit    = w_bit_term;
    assign cnt_if.last_byte   = w_bit_term & w_byte_term;
    assign cnt_if.last_pixel  = w_pix_term;
    assign cnt_if.frame_end   = w_frame_end;
    assign cnt_if.done        = done_q;
    assign cnt_if.frame_pulse = pulse_q;

endmodule : grb_frame_counter
`default_nettype wire

// File: tb/tb_grb_frame_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_grb_frame_counter
// Purpose : Self-checking bench for grb_frame_counter. Four instances with
//           different geometry share one strobe stream; each is compared
//           every cycle against a flat-position reference model.
//             dut0: 2 LEDs x 3 bytes, one-shot
//             dut1: 2 LEDs x 3 bytes, wrapping
//             dut2: 3 LEDs x 4 bytes, wrapping
//             dut3: 1 LED  x 3 bytes, one-shot
// Revision: 1.0  initial release
// ============================================================================
module tb_grb_frame_counter;

    logic clk;
    logic rst;
    logic clr;
    logic inc;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    grb_frame_counter_if #(.NUM_LEDS(2), .BYTES_PER_LED(3)) if0 ();
    grb_frame_counter_if #(.NUM_LEDS(2), .BYTES_PER_LED(3)) if1 ();
    grb_frame_counter_if #(.NUM_LEDS(3), .BYTES_PER_LED(4)) if2 ();
    grb_frame_counter_if #(.NUM_LEDS(1), .BYTES_PER_LED(3)) if3 ();

    assign if0.clear_i = clr;  assign if0.inc_i = inc;
    assign if1.clear_i = clr;  assign if1.inc_i = inc;
    assign if2.clear_i = clr;  assign if2.inc_i = inc;
    assign if3.clear_i = clr;  assign if3.inc_i = inc;

    grb_frame_counter #(.NUM_LEDS(2), .BYTES_PER_LED(3), .WRAP(0)) dut0 (.clk(clk), .reset(rst), .cnt_if(if0));
    grb_frame_counter #(.NUM_LEDS(2), .BYTES_PER_LED(3), .WRAP(1)) dut1 (.clk(clk), .reset(rst), .cnt_if(if1));
    grb_frame_counter #(.NUM_LEDS(3), .BYTES_PER_LED(4), .WRAP(1)) dut2 (.clk(clk), .reset(rst), .cnt_if(if2));
    grb_frame_counter #(.NUM_LEDS(1), .BYTES_PER_LED(3), .WRAP(0)) dut3 (.clk(clk), .reset(rst), .cnt_if(if3));

    // Observed state packed as {bit, byte, pixel, total, last_bit, last_byte,
    // last_pixel, frame_end, done, frame_pulse}.
    logic [3:0][63:0] obs;
    assign obs[0] = {29'd0, if0.bit_idx, if0.byte_idx, 8'(if0.pixel_idx), 16'(if0.total_count),
                     if0.last_bit, if0.last_byte, if0.last_pixel, if0.frame_end, if0.done, if0.frame_pulse};
    assign obs[1] = {29'd0, if1.bit_idx, if1.byte_idx, 8'(if1.pixel_idx), 16'(if1.total_count),
                     if1.last_bit, if1.last_byte, if1.last_pixel, if1.frame_end, if1.done, if1.frame_pulse};
    assign obs[2] = {29'd0, if2.bit_idx, if2.byte_idx, 8'(if2.pixel_idx), 16'(if2.total_count),
                     if2.last_bit, if2.last_byte, if2.last_pixel, if2.frame_end, if2.done, if2.frame_pulse};
    assign obs[3] = {29'd0, if3.bit_idx, if3.byte_idx, 8'(if3.pixel_idx), 16'(if3.total_count),
                     if3.last_bit, if3.last_byte, if3.last_pixel, if3.frame_end, if3.done, if3.frame_pulse};

    // Reference model: a flat bit position k per instance plus done/pulse.
    int cfg_n [4] = '{2, 2, 3, 1};
    int cfg_b [4] = '{3, 3, 4, 3};
    int cfg_w [4] = '{0, 1, 1, 0};
    int k     [4];
    bit mdone [4];
    bit mpulse[4];

    function automatic logic [63:0] exp_vec(input int d);
        int   total;
        int   eb;
        int   ey;
        int   ep;
        int   et;
        logic lb;
        logic lby;
        logic lp;
        logic fe;
        total = cfg_n[d] * cfg_b[d] * 8;
        if (mdone[d]) begin
            eb = 7;
            ey = cfg_b[d] - 1;
            ep = cfg_n[d] - 1;
            et = total;
        end else begin
            eb = k[d] % 8;
            ey = (k[d] / 8) % cfg_b[d];
            ep = k[d] / (8 * cfg_b[d]);
            et = k[d];
        end
        lb  = (eb == 7);
        lby = lb && (ey == cfg_b[d] - 1);
        lp  = (ep == cfg_n[d] - 1);
        fe  = lby && lp;
        return {29'd0, 3'(eb), 2'(ey), 8'(ep), 16'(et), lb, lby, lp, fe, mdone[d], mpulse[d]};
    endfunction

    task automatic model_step();
        int total;
        for (int d = 0; d < 4; d++) begin
            total = cfg_n[d] * cfg_b[d] * 8;
            if (rst || clr) begin
                k[d]      = 0;
                mdone[d]  = 1'b0;
                mpulse[d] = 1'b0;
            end else if (inc && !mdone[d]) begin
                mpulse[d] = (k[d] == total - 1);
                if (k[d] == total - 1) begin
                    if (cfg_w[d] != 0) begin
                        k[d] = 0;
                    end else begin
                        k[d]     = total;
                        mdone[d] = 1'b1;
                    end
                end else begin
                    k[d] = k[d] + 1;
                end
            end else begin
                mpulse[d] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; inc = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs[d] !== exp_vec(d)) begin
                failures++;
                $display("FAIL reset dut%0d got=%h want=%h", d, obs[d], exp_vec(d));
            end
        end
        checks++;
        if (if3.last_pixel !== 1'b1 || if0.last_pixel !== 1'b0) begin
            failures++;
            $display("FAIL reset_last_pixel got n1=%b n2=%b want n1=1 n2=0", if3.last_pixel, if0.last_pixel);
        end
        rst = 1'b0; inc = 1'b0;
    endtask

    task automatic test_bit_wrap();
        clr = 1'b1; tick(); clr = 1'b0; inc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL bit_wrap step%0d dut%0d got=%h want=%h", i, d, obs[d], exp_vec(d));
                end
            end
            if (i == 7) begin
                checks++;
                if (if0.bit_idx !== 3'd7 || if0.last_bit !== 1'b1) begin
                    failures++;
                    $display("FAIL bit7 got bit=%0d last_bit=%b want bit=7 last_bit=1", if0.bit_idx, if0.last_bit);
                end
            end
            if (i == 8) begin
                checks++;
                if (if0.bit_idx !== 3'd0 || if0.byte_idx !== 2'd1 || if0.total_count !== 6'd8) begin
                    failures++;
                    $display("FAIL byte_step got bit=%0d byte=%0d total=%0d want 0 1 8",
                             if0.bit_idx, if0.byte_idx, if0.total_count);
                end
            end
        end
        inc = 1'b0;
    endtask

    task automatic test_frame_end();
        clr = 1'b1; tick(); clr = 1'b0; inc = 1'b1;
        for (int i = 1; i <= 53; i++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL frame step%0d dut%0d got=%h want=%h", i, d, obs[d], exp_vec(d));
                end
            end
            if (i == 47) begin
                checks++;
                if (if0.frame_end !== 1'b1 || if0.frame_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_end_47 got fe=%b pulse=%b want 1 0", if0.frame_end, if0.frame_pulse);
                end
            end
            if (i == 48) begin
                checks++;
                if (if0.done !== 1'b1 || if0.frame_pulse !== 1'b1 || if0.total_count !== 6'd48 ||
                    if0.pixel_idx !== 1'd1 || if0.byte_idx !== 2'd2 || if0.bit_idx !== 3'd7) begin
                    failures++;
                    $display("FAIL oneshot_end got=%h want done=1 pulse=1 total=48 pos=1/2/7", obs[0]);
                end
                checks++;
                if (if1.done !== 1'b0 || if1.frame_pulse !== 1'b1 || if1.total_count !== 6'd0 ||
                    if1.pixel_idx !== 1'd0 || if1.byte_idx !== 2'd0 || if1.bit_idx !== 3'd0) begin
                    failures++;
                    $display("FAIL wrap_end got=%h want done=0 pulse=1 total=0 pos=0/0/0", obs[1]);
                end
            end
            if (i == 49) begin
                checks++;
                if (if0.frame_pulse !== 1'b0 || if1.frame_pulse !== 1'b0 || if1.total_count !== 6'd1) begin
                    failures++;
                    $display("FAIL after_end got p0=%b p1=%b total1=%0d want 0 0 1",
                             if0.frame_pulse, if1.frame_pulse, if1.total_count);
                end
            end
        end
        checks++;
        if (if0.total_count !== 6'd48 || if0.done !== 1'b1 || if0.bit_idx !== 3'd7) begin
            failures++;
            $display("FAIL oneshot_hold got total=%0d done=%b bit=%0d want 48 1 7",
                     if0.total_count, if0.done, if0.bit_idx);
        end
        inc = 1'b0;
    endtask

    task automatic test_clear_collision();
        clr = 1'b1; tick(); clr = 1'b0; inc = 1'b1;
        repeat (20) tick();
        checks++;
        if (if0.total_count !== 6'd20) begin
            failures++;
            $display("FAIL count20 got=%0d want=20", if0.total_count);
        end
        clr = 1'b1; inc = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs[d] !== exp_vec(d)) begin
                failures++;
                $display("FAIL clear_inc dut%0d got=%h want=%h", d, obs[d], exp_vec(d));
            end
        end
        checks++;
        if (if0.total_count !== 6'd0 || if0.bit_idx !== 3'd0 || if0.byte_idx !== 2'd0) begin
            failures++;
            $display("FAIL clear_wins got total=%0d bit=%0d byte=%0d want 0 0 0",
                     if0.total_count, if0.bit_idx, if0.byte_idx);
        end
        clr = 1'b0;
        repeat (48) tick();
        checks++;
        if (if0.done !== 1'b1) begin
            failures++;
            $display("FAIL done_before_clear got=%b want=1", if0.done);
        end
        inc = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs[d] !== exp_vec(d)) begin
                failures++;
                $display("FAIL clear_done dut%0d got=%h want=%h", d, obs[d], exp_vec(d));
            end
        end
        checks++;
        if (if0.done !== 1'b0) begin
            failures++;
            $display("FAIL done_cleared got=%b want=0", if0.done);
        end
    endtask

    task automatic test_nonpow2();
        int maxpix;
        bit seen3;
        maxpix = 0;
        seen3  = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0; inc = 1'b1;
        for (int i = 1; i <= 96; i++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL nonpow2 step%0d dut%0d got=%h want=%h", i, d, obs[d], exp_vec(d));
                end
            end
            if (int'(if2.pixel_idx) > maxpix) maxpix = int'(if2.pixel_idx);
            if (if2.byte_idx == 2'd3) seen3 = 1'b1;
        end
        checks++;
        if (maxpix != 2 || !seen3) begin
            failures++;
            $display("FAIL nonpow2_range got maxpix=%0d byte3=%b want 2 1", maxpix, seen3);
        end
        checks++;
        if (if2.pixel_idx !== 2'd0 || if2.total_count !== 7'd0 || if2.frame_pulse !== 1'b1) begin
            failures++;
            $display("FAIL nonpow2_wrap got pix=%0d total=%0d pulse=%b want 0 0 1",
                     if2.pixel_idx, if2.total_count, if2.frame_pulse);
        end
        inc = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 59) == 0);
            inc = ($urandom_range(0, 3) != 0);
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL random cyc%0d dut%0d got=%h want=%h", i, d, obs[d], exp_vec(d));
                end
            end
        end
        rst = 1'b0; clr = 1'b0; inc = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        inc = 1'b0;
        for (int d = 0; d < 4; d++) begin
            k[d]      = 0;
            mdone[d]  = 1'b0;
            mpulse[d] = 1'b0;
        end
        #2;
        test_reset();
        test_bit_wrap();
        test_frame_end();
        test_clear_collision();
        test_nonpow2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_grb_frame_counter
`default_nettype wire
